// File: rtl/ddr4_dqsw_wrlvl_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ddr4_dqsw_wrlvl_ctrl_if
// Brief    : Control, status and DQSW IOD training signals for one DQS lane.
// Revision : 1.0 - initial release
// ============================================================================
interface ddr4_dqsw_wrlvl_ctrl_if #(
   parameter int TAP_W = 8
);
   logic             START;
   logic             BUSY;
   logic             DONE;
   logic             FAIL;
   logic [TAP_W-1:0] TAP_OUT;
   logic [1:0]       TX_DATA_0;
   logic [1:0]       OE_DATA_0;
   logic             ODT_EN_0;
   logic             DELAY_LINE_LOAD_0;
   logic             DELAY_LINE_MOVE_0;
   logic             DELAY_LINE_DIRECTION_0;
   logic             DELAY_LINE_OUT_OF_RANGE_0;
   logic [1:0]       RX_DATA_0;

   modport master (
      input  START, DELAY_LINE_OUT_OF_RANGE_0, RX_DATA_0,
      output BUSY, DONE, FAIL, TAP_OUT, TX_DATA_0, OE_DATA_0, ODT_EN_0,
             DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0
   );

   modport slave (
      output START, DELAY_LINE_OUT_OF_RANGE_0, RX_DATA_0,
      input  BUSY, DONE, FAIL, TAP_OUT, TX_DATA_0, OE_DATA_0, ODT_EN_0,
             DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0
   );
endinterface
`default_nettype wire

// File: rtl/ddr4_dqsw_wrlvl_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ddr4_dqsw_wrlvl_ctrl
// Brief    : DDR4 write-leveling engine: sweeps DQS delay up to the 0->1
//            feedback edge. Optional macro DQSW_WRLVL_BACKOFF_EN steps back
//            BACKOFF_TAPS taps after the edge is found.
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_dqsw_wrlvl_ctrl #(
   parameter int TAP_W         = 8,
   parameter int MAX_TAPS      = 255,
   parameter int SETTLE_CYCLES = 8,
   parameter int FB_WAIT       = 16,
   parameter int SAMPLES       = 4
`ifdef DQSW_WRLVL_BACKOFF_EN
   ,
   parameter int BACKOFF_TAPS  = 4
`endif
) (
   input wire                     FAB_CLK,
   input wire                     RESET,
   ddr4_dqsw_wrlvl_ctrl_if.master bus
);
   localparam int c_cnt_max = (SETTLE_CYCLES > FB_WAIT) ? SETTLE_CYCLES : FB_WAIT;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

   localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_fb_last     = c_cnt_w'(FB_WAIT - 1);
   localparam logic [TAP_W-1:0]   c_max_tap     = TAP_W'(MAX_TAPS);
   localparam logic [3:0]         c_samples     = 4'(SAMPLES);

   localparam logic [3:0] c_st_idle      = 4'd0;
   localparam logic [3:0] c_st_load      = 4'd1;
   localparam logic [3:0] c_st_settle    = 4'd2;
   localparam logic [3:0] c_st_pulse     = 4'd3;
   localparam logic [3:0] c_st_wait_fb   = 4'd4;
   localparam logic [3:0] c_st_sample    = 4'd5;
   localparam logic [3:0] c_st_step      = 4'd6;
   localparam logic [3:0] c_st_finish    = 4'd7;
   localparam logic [3:0] c_st_fail      = 4'd8;
`ifdef DQSW_WRLVL_BACKOFF_EN
   localparam logic [3:0] c_st_bk_check  = 4'd9;
   localparam logic [3:0] c_st_bk_move   = 4'd10;
   localparam logic [3:0] c_st_bk_settle = 4'd11;
   localparam logic [TAP_W-1:0] c_backoff = TAP_W'(BACKOFF_TAPS);
`endif

   logic [3:0]         r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [3:0]         r_pulse_cnt;
   logic [3:0]         r_ones_cnt;
   logic [TAP_W-1:0]   r_tap;
   logic               r_seen_zero;
   logic               r_done;
   logic               r_fail;
   logic [TAP_W-1:0]   r_tap_out;

   logic               w_sample;
   logic [3:0]         w_ones_next;
   logic [3:0]         w_pulse_next;
   logic               w_last_pulse;
   logic               w_vote;
   logic               w_step_stop;

   assign w_sample     = (bus.RX_DATA_0 == 2'b11);
   assign w_ones_next  = r_ones_cnt + {3'b000, w_sample};
   assign w_pulse_next = r_pulse_cnt + 4'd1;
   assign w_last_pulse = (w_pulse_next >= c_samples);
   // Strict majority: a tie (ones*2 == SAMPLES) votes 0.
   assign w_vote       = ({w_ones_next, 1'b0} > 5'(SAMPLES));
   assign w_step_stop  = (r_tap == c_max_tap) || bus.DELAY_LINE_OUT_OF_RANGE_0;

`ifdef DQSW_WRLVL_BACKOFF_EN
   logic             r_dir;
   logic [TAP_W-1:0] r_back_cnt;
   logic [TAP_W-1:0] w_back_amt;

   assign w_back_amt = (r_tap < c_backoff) ? r_tap : c_backoff;
`endif

   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         r_state     <= c_st_idle;
         r_cnt       <= '0;
         r_pulse_cnt <= '0;
         r_ones_cnt  <= '0;
         r_tap       <= '0;
         r_seen_zero <= 1'b0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
         r_tap_out   <= '0;
`ifdef DQSW_WRLVL_BACKOFF_EN
         r_dir       <= 1'b1;
         r_back_cnt  <= '0;
`endif
      end else begin
         case (r_state)
            c_st_idle: begin
               if (bus.START) begin
                  r_state     <= c_st_load;
                  r_done      <= 1'b0;
                  r_fail      <= 1'b0;
                  r_tap_out   <= '0;
                  r_tap       <= '0;
                  r_seen_zero <= 1'b0;
                  r_cnt       <= '0;
                  r_pulse_cnt <= '0;
                  r_ones_cnt  <= '0;
               end
            end
            c_st_load: begin
               r_cnt   <= '0;
               r_state <= c_st_settle;
            end
            c_st_settle: begin
               if (r_cnt == c_settle_last) begin
                  r_cnt   <= '0;
                  r_state <= c_st_pulse;
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            c_st_pulse: begin
               r_cnt   <= '0;
               r_state <= c_st_wait_fb;
            end
            c_st_wait_fb: begin
               if (r_cnt == c_fb_last) begin
                  r_cnt   <= '0;
                  r_state <= c_st_sample;
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            c_st_sample: begin
               if (!w_last_pulse) begin
                  r_ones_cnt  <= w_ones_next;
                  r_pulse_cnt <= w_pulse_next;
                  r_state     <= c_st_pulse;
               end else begin
                  r_ones_cnt  <= '0;
                  r_pulse_cnt <= '0;
                  // A 1 before any 0 belongs to the previous clock edge; keep sweeping.
                  if (!w_vote) begin
                     r_seen_zero <= 1'b1;
                     r_state     <= c_st_step;
                  end else if (r_seen_zero) begin
`ifdef DQSW_WRLVL_BACKOFF_EN
                     r_back_cnt <= w_back_amt;
                     r_dir      <= 1'b0;
                     r_state    <= c_st_bk_check;
`else
                     r_state    <= c_st_finish;
`endif
                  end else begin
                     r_state <= c_st_step;
                  end
               end
            end
            c_st_step: begin
               if (w_step_stop) begin
                  r_state <= c_st_fail;
               end else begin
                  r_tap   <= r_tap + TAP_W'(1);
                  r_cnt   <= '0;
                  r_state <= c_st_settle;
               end
            end
            c_st_finish: begin
               r_tap_out <= r_tap;
               r_done    <= 1'b1;
               r_state   <= c_st_idle;
            end
            c_st_fail: begin
               r_tap_out <= '0;
               r_fail    <= 1'b1;
               r_state   <= c_st_idle;
            end
`ifdef DQSW_WRLVL_BACKOFF_EN
            c_st_bk_check: begin
               if (r_back_cnt == '0) begin
                  r_dir   <= 1'b1;
                  r_state <= c_st_finish;
               end else begin
                  r_state <= c_st_bk_move;
               end
            end
            c_st_bk_move: begin
               r_tap      <= r_tap - TAP_W'(1);
               r_back_cnt <= r_back_cnt - TAP_W'(1);
               r_cnt      <= '0;
               r_state    <= c_st_bk_settle;
            end
            c_st_bk_settle: begin
               if (r_cnt == c_settle_last) begin
                  r_cnt   <= '0;
                  r_state <= c_st_bk_check;
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
`endif
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign bus.BUSY              = (r_state != c_st_idle);
   assign bus.DONE              = r_done;
   assign bus.FAIL              = r_fail;
   assign bus.TAP_OUT           = r_tap_out;
   assign bus.TX_DATA_0         = (r_state == c_st_pulse) ? 2'b10 : 2'b00;
   assign bus.OE_DATA_0         = ((r_state >= c_st_load) && (r_state <= c_st_step)) ? 2'b11 : 2'b00;
   assign bus.ODT_EN_0          = (r_state == c_st_idle);
   assign bus.DELAY_LINE_LOAD_0 = (r_state == c_st_load);
`ifdef DQSW_WRLVL_BACKOFF_EN
   assign bus.DELAY_LINE_MOVE_0      = ((r_state == c_st_step) && !w_step_stop) ||
                                       (r_state == c_st_bk_move);
   assign bus.DELAY_LINE_DIRECTION_0 = r_dir;
`else
   assign bus.DELAY_LINE_MOVE_0      = (r_state == c_st_step) && !w_step_stop;
   assign bus.DELAY_LINE_DIRECTION_0 = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr4_dqsw_wrlvl_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ddr4_dqsw_wrlvl_ctrl
// Brief    : Directed bench for ddr4_dqsw_wrlvl_ctrl with a tap-indexed DRAM
//            feedback model; backoff cases build when DQSW_WRLVL_BACKOFF_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr4_dqsw_wrlvl_ctrl;
   localparam int TAP_W   = 8;
   localparam int TIMEOUT = 25000;

   logic FAB_CLK = 1'b0;
   logic RESET   = 1'b1;

   int tests_run    = 0;
   int tests_failed = 0;

   // Feedback model controls (written only by the main initial block)
   int         fb_mode  = 2;
   int         edge_tap = 0;
   int         oor_tap  = 1000;
   logic [3:0] vote_pat = 4'b0000;

   // Observed IOD activity (written only by the monitor)
   int tb_tap     = 0;
   int pulse_idx  = 0;
   int up_moves   = 0;
   int down_moves = 0;
   int loads      = 0;

   ddr4_dqsw_wrlvl_ctrl_if #(.TAP_W(TAP_W)) bus ();

   ddr4_dqsw_wrlvl_ctrl #(
      .TAP_W         (TAP_W),
      .MAX_TAPS      (255),
      .SETTLE_CYCLES (8),
      .FB_WAIT       (16),
      .SAMPLES       (4)
`ifdef DQSW_WRLVL_BACKOFF_EN
      ,
      .BACKOFF_TAPS  (4)
`endif
   ) dut (
      .FAB_CLK (FAB_CLK),
      .RESET   (RESET),
      .bus     (bus)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   always @(negedge FAB_CLK) begin
      if (bus.DELAY_LINE_LOAD_0 === 1'b1) begin
         loads     <= loads + 1;
         tb_tap    <= 0;
         pulse_idx <= 0;
      end else if (bus.DELAY_LINE_MOVE_0 === 1'b1) begin
         pulse_idx <= 0;
         if (bus.DELAY_LINE_DIRECTION_0) begin
            up_moves <= up_moves + 1;
            tb_tap   <= tb_tap + 1;
         end else begin
            down_moves <= down_moves + 1;
            tb_tap     <= tb_tap - 1;
         end
      end else if (bus.TX_DATA_0 === 2'b10) begin
         pulse_idx <= pulse_idx + 1;
      end
   end

   function automatic logic [1:0] fb_value(input int tap, input int idx);
      logic one;
      case (fb_mode)
         0:       one = (tap >= edge_tap);
         1:       one = (tap <= 5) || (tap >= 41);
         2:       one = 1'b0;
         default: one = (tap > 10) || ((tap == 10) && (idx >= 1) && (idx <= 4) && vote_pat[idx-1]);
      endcase
      // Mode 2 returns a half-high pattern, which must still count as 0.
      if (one)               return 2'b11;
      else if (fb_mode == 2) return 2'b01;
      else                   return 2'b00;
   endfunction

   function automatic int exp_tap(input int edge_at);
`ifdef DQSW_WRLVL_BACKOFF_EN
      return (edge_at > 4) ? edge_at - 4 : 0;
`else
      return edge_at;
`endif
   endfunction

   function automatic int exp_down(input int edge_at);
`ifdef DQSW_WRLVL_BACKOFF_EN
      return (edge_at > 4) ? 4 : edge_at;
`else
      return 0 * edge_at;
`endif
   endfunction

   initial begin
      bus.RX_DATA_0                 = 2'b00;
      bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
      forever begin
         @(posedge FAB_CLK);
         #1;
         bus.RX_DATA_0                 = fb_value(tb_tap, pulse_idx);
         bus.DELAY_LINE_OUT_OF_RANGE_0 = (tb_tap >= oor_tap);
      end
   end

   task automatic run_sweep(output int cycles, output logic busy_before);
      cycles      = 0;
      busy_before = 1'b0;
      @(posedge FAB_CLK); #2 bus.START = 1'b1;
      @(posedge FAB_CLK); #2 bus.START = 1'b0;
      while (!(bus.DONE === 1'b1 || bus.FAIL === 1'b1) && cycles < TIMEOUT) begin
         busy_before = bus.BUSY;
         @(posedge FAB_CLK); #2;
         cycles++;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(posedge FAB_CLK);
      #2;
      tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
      tests_run++; if (bus.DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", bus.DONE); end
      tests_run++; if (bus.FAIL !== 1'b0) begin tests_failed++; $display("FAIL reset_fail: got %b want 0", bus.FAIL); end
      tests_run++; if (bus.TAP_OUT !== 8'd0) begin tests_failed++; $display("FAIL reset_tap_out: got %0d want 0", bus.TAP_OUT); end
      tests_run++; if (bus.TX_DATA_0 !== 2'b00) begin tests_failed++; $display("FAIL reset_tx: got %b want 00", bus.TX_DATA_0); end
      tests_run++; if (bus.OE_DATA_0 !== 2'b00) begin tests_failed++; $display("FAIL reset_oe: got %b want 00", bus.OE_DATA_0); end
      tests_run++; if (bus.ODT_EN_0 !== 1'b1) begin tests_failed++; $display("FAIL reset_odt: got %b want 1", bus.ODT_EN_0); end
      tests_run++; if (bus.DELAY_LINE_LOAD_0 !== 1'b0) begin tests_failed++; $display("FAIL reset_load: got %b want 0", bus.DELAY_LINE_LOAD_0); end
      tests_run++; if (bus.DELAY_LINE_MOVE_0 !== 1'b0) begin tests_failed++; $display("FAIL reset_move: got %b want 0", bus.DELAY_LINE_MOVE_0); end
      tests_run++; if (bus.DELAY_LINE_DIRECTION_0 !== 1'b1) begin tests_failed++; $display("FAIL reset_dir: got %b want 1", bus.DELAY_LINE_DIRECTION_0); end
      RESET = 1'b0;
   endtask

   // Edge at 37: 1 LOAD + 38 taps * 81 cycles - 1 (no STEP on last) + 1 FINISH = 3079
   task automatic test_edge37();
      int   cyc;
      logic bb;
      int   up0 = up_moves, dn0 = down_moves, ld0 = loads;
      logic [TAP_W-1:0] want = TAP_W'(exp_tap(37));
      fb_mode = 0; edge_tap = 37; oor_tap = 1000;
      run_sweep(cyc, bb);
      tests_run++; if (bus.DONE !== 1'b1) begin tests_failed++; $display("FAIL e37_done: got %b want 1 after %0d cycles", bus.DONE, cyc); end
      tests_run++; if (bus.FAIL !== 1'b0) begin tests_failed++; $display("FAIL e37_fail: got %b want 0", bus.FAIL); end
      tests_run++; if (bus.TAP_OUT !== want) begin tests_failed++; $display("FAIL e37_tap_out: got %0d want %0d", bus.TAP_OUT, want); end
      tests_run++; if (up_moves - up0 != 37) begin tests_failed++; $display("FAIL e37_up_moves: got %0d want 37", up_moves - up0); end
      tests_run++; if (down_moves - dn0 != exp_down(37)) begin tests_failed++; $display("FAIL e37_down_moves: got %0d want %0d", down_moves - dn0, exp_down(37)); end
      tests_run++; if (loads - ld0 != 1) begin tests_failed++; $display("FAIL e37_loads: got %0d want 1", loads - ld0); end
      tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL e37_busy_at_done: got %b want 0", bus.BUSY); end
      tests_run++; if (bb !== 1'b1) begin tests_failed++; $display("FAIL e37_busy_before_done: got %b want 1", bb); end
      tests_run++; if (bus.ODT_EN_0 !== 1'b1) begin tests_failed++; $display("FAIL e37_odt_idle: got %b want 1", bus.ODT_EN_0); end
      tests_run++; if (bus.DELAY_LINE_DIRECTION_0 !== 1'b1) begin tests_failed++; $display("FAIL e37_dir_idle: got %b want 1", bus.DELAY_LINE_DIRECTION_0); end
`ifndef DQSW_WRLVL_BACKOFF_EN
      tests_run++; if (cyc != 3079) begin tests_failed++; $display("FAIL e37_latency: got %0d want 3079", cyc); end
`endif
   endtask

   task automatic test_initial_high();
      int   cyc;
      logic bb;
      int   up0 = up_moves;
      logic [TAP_W-1:0] want = TAP_W'(exp_tap(41));
      fb_mode = 1; oor_tap = 1000;
      run_sweep(cyc, bb);
      tests_run++; if (bus.DONE !== 1'b1) begin tests_failed++; $display("FAIL ihigh_done: got %b want 1 after %0d cycles", bus.DONE, cyc); end
      tests_run++; if (bus.FAIL !== 1'b0) begin tests_failed++; $display("FAIL ihigh_fail: got %b want 0", bus.FAIL); end
      tests_run++; if (bus.TAP_OUT !== want) begin tests_failed++; $display("FAIL ihigh_tap_out: got %0d want %0d", bus.TAP_OUT, want); end
      tests_run++; if (up_moves - up0 != 41) begin tests_failed++; $display("FAIL ihigh_up_moves: got %0d want 41", up_moves - up0); end
   endtask

   task automatic test_out_of_range();
      int   cyc;
      logic bb;
      int   up0 = up_moves;
      fb_mode = 2; oor_tap = 20;
      run_sweep(cyc, bb);
      tests_run++; if (bus.FAIL !== 1'b1) begin tests_failed++; $display("FAIL oor_fail: got %b want 1 after %0d cycles", bus.FAIL, cyc); end
      tests_run++; if (bus.DONE !== 1'b0) begin tests_failed++; $display("FAIL oor_done: got %b want 0", bus.DONE); end
      tests_run++; if (bus.TAP_OUT !== 8'd0) begin tests_failed++; $display("FAIL oor_tap_out: got %0d want 0", bus.TAP_OUT); end
      tests_run++; if (up_moves - up0 != 20) begin tests_failed++; $display("FAIL oor_moves: got %0d want 20", up_moves - up0); end
      tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL oor_busy: got %b want 0", bus.BUSY); end
      oor_tap = 1000;
   endtask

   task automatic test_max_taps();
      int   cyc;
      logic bb;
      int   up0 = up_moves;
      fb_mode = 2; oor_tap = 1000;
      run_sweep(cyc, bb);
      tests_run++; if (bus.FAIL !== 1'b1) begin tests_failed++; $display("FAIL max_fail: got %b want 1 after %0d cycles", bus.FAIL, cyc); end
      tests_run++; if (bus.DONE !== 1'b0) begin tests_failed++; $display("FAIL max_done: got %b want 0", bus.DONE); end
      tests_run++; if (up_moves - up0 != 255) begin tests_failed++; $display("FAIL max_moves: got %0d want 255", up_moves - up0); end
      tests_run++; if (bus.TAP_OUT !== 8'd0) begin tests_failed++; $display("FAIL max_tap_out: got %0d want 0", bus.TAP_OUT); end
   endtask

   task automatic test_majority_vote();
      int   cyc;
      logic bb;
      int   up0;
      logic [TAP_W-1:0] want;
      fb_mode = 3; oor_tap = 1000;
      // Samples 1,0,1,1 at tap 10: three of four -> edge at 10
      vote_pat = 4'b1101; up0 = up_moves; want = TAP_W'(exp_tap(10));
      run_sweep(cyc, bb);
      tests_run++; if (bus.DONE !== 1'b1) begin tests_failed++; $display("FAIL vote3_done: got %b want 1", bus.DONE); end
      tests_run++; if (bus.TAP_OUT !== want) begin tests_failed++; $display("FAIL vote3_tap_out: got %0d want %0d", bus.TAP_OUT, want); end
      tests_run++; if (up_moves - up0 != 10) begin tests_failed++; $display("FAIL vote3_moves: got %0d want 10", up_moves - up0); end
      // Samples 1,0,1,0: tie counts as 0, so tap 11 is the edge
      vote_pat = 4'b0101; up0 = up_moves; want = TAP_W'(exp_tap(11));
      run_sweep(cyc, bb);
      tests_run++; if (bus.DONE !== 1'b1) begin tests_failed++; $display("FAIL vote_tie_done: got %b want 1", bus.DONE); end
      tests_run++; if (bus.TAP_OUT !== want) begin tests_failed++; $display("FAIL vote_tie_tap_out: got %0d want %0d", bus.TAP_OUT, want); end
      tests_run++; if (up_moves - up0 != 11) begin tests_failed++; $display("FAIL vote_tie_moves: got %0d want 11", up_moves - up0); end
   endtask

   task automatic test_reset_mid_sample();
      int   cyc = 0;
      logic bb;
      int   up0, ld0;
      logic [TAP_W-1:0] want = TAP_W'(exp_tap(5));
      fb_mode = 2; oor_tap = 1000;
      @(posedge FAB_CLK); #2 bus.START = 1'b1;
      @(posedge FAB_CLK); #2 bus.START = 1'b0;
      while (!(tb_tap == 12 && pulse_idx == 1) && cyc < TIMEOUT) begin
         @(posedge FAB_CLK); #2;
         cyc++;
      end
      tests_run++; if (cyc >= TIMEOUT) begin tests_failed++; $display("FAIL rst_reach_tap12: got timeout want tap 12 pulse"); end
      // First pulse at tap 12 just ended; after FB_WAIT cycles the DUT is in SAMPLE
      repeat (16) begin @(posedge FAB_CLK); #2; end
      RESET = 1'b1;
      @(posedge FAB_CLK); #2;
      RESET = 1'b0;
      tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", bus.BUSY); end
      tests_run++; if (bus.OE_DATA_0 !== 2'b00) begin tests_failed++; $display("FAIL rst_oe: got %b want 00", bus.OE_DATA_0); end
      tests_run++; if (bus.ODT_EN_0 !== 1'b1) begin tests_failed++; $display("FAIL rst_odt: got %b want 1", bus.ODT_EN_0); end
      tests_run++; if (bus.TAP_OUT !== 8'd0) begin tests_failed++; $display("FAIL rst_tap_out: got %0d want 0", bus.TAP_OUT); end
      up0 = up_moves; ld0 = loads;
      repeat (300) @(posedge FAB_CLK);
      #2;
      tests_run++; if (up_moves != up0) begin tests_failed++; $display("FAIL rst_no_move: got %0d moves want 0", up_moves - up0); end
      tests_run++; if (loads != ld0) begin tests_failed++; $display("FAIL rst_no_load: got %0d loads want 0", loads - ld0); end
      fb_mode = 0; edge_tap = 5; up0 = up_moves;
      run_sweep(cyc, bb);
      tests_run++; if (bus.DONE !== 1'b1) begin tests_failed++; $display("FAIL rst_restart_done: got %b want 1", bus.DONE); end
      tests_run++; if (bus.TAP_OUT !== want) begin tests_failed++; $display("FAIL rst_restart_tap_out: got %0d want %0d", bus.TAP_OUT, want); end
      tests_run++; if (up_moves - up0 != 5) begin tests_failed++; $display("FAIL rst_restart_moves: got %0d want 5", up_moves - up0); end
   endtask

`ifdef DQSW_WRLVL_BACKOFF_EN
   task automatic test_backoff_low_edge();
      int   cyc;
      logic bb;
      int   up0 = up_moves, dn0 = down_moves;
      fb_mode = 0; edge_tap = 2; oor_tap = 1000;
      run_sweep(cyc, bb);
      tests_run++; if (bus.DONE !== 1'b1) begin tests_failed++; $display("FAIL bk2_done: got %b want 1", bus.DONE); end
      tests_run++; if (up_moves - up0 != 2) begin tests_failed++; $display("FAIL bk2_up_moves: got %0d want 2", up_moves - up0); end
      tests_run++; if (down_moves - dn0 != 2) begin tests_failed++; $display("FAIL bk2_down_moves: got %0d want 2", down_moves - dn0); end
      tests_run++; if (bus.TAP_OUT !== 8'd0) begin tests_failed++; $display("FAIL bk2_tap_out: got %0d want 0", bus.TAP_OUT); end
      tests_run++; if (bus.DELAY_LINE_DIRECTION_0 !== 1'b1) begin tests_failed++; $display("FAIL bk2_dir: got %b want 1", bus.DELAY_LINE_DIRECTION_0); end
   endtask
`endif

   initial begin
      bus.START = 1'b0;
      test_reset();
      test_edge37();
      test_initial_high();
      test_out_of_range();
      test_max_taps();
      test_majority_vote();
      test_reset_mid_sample();
`ifdef DQSW_WRLVL_BACKOFF_EN
      test_backoff_low_edge();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
